// File: rtl/preco_pkg.sv
// Shared constants and types for the preco price calculator.
package preco_pkg;

    localparam int WIDTH = 16;
    localparam logic [WIDTH-1:0] SAT_MAX = {WIDTH{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/preco_shift_add.sv
// Shift-add multiplier datapath: one multiplier bit per step, saturating result
// registered on the final step.
module preco_shift_add
    import preco_pkg::*;
#(
    parameter int WIDTH_P = WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH_P-1:0] weight_kg,
    input  logic [WIDTH_P-1:0] price_per_kg,
    output logic               last,
    output logic [WIDTH_P-1:0] total_price,
    output logic               overflow
);

    localparam int CW = $clog2(WIDTH_P + 1);

    logic [2*WIDTH_P-1:0] mcand_q, mcand_d;
    logic [2*WIDTH_P-1:0] acc_q, acc_d;
    logic [2*WIDTH_P-1:0] acc_sum;
    logic [WIDTH_P-1:0]   mplr_q, mplr_d;
    logic [WIDTH_P-1:0]   total_q, total_d;
    logic                 ovf_q, ovf_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    assign last        = (cnt_q == CW'(1));
    assign total_price = total_q;
    assign overflow    = ovf_q;

    always_comb begin
        // The final step's add must be included in the saturation check.
        acc_sum = acc_q + (mplr_q[0] ? mcand_q : '0);
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        ovf_d   = ovf_q;
        if (load) begin
            mcand_d = {{WIDTH_P{1'b0}}, price_per_kg};
            mplr_d  = weight_kg;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH_P);
        end else if (step) begin
            acc_d   = acc_sum;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q - CW'(1);
            if (last) begin
                if (|acc_sum[2*WIDTH_P-1:WIDTH_P]) begin
                    total_d = {WIDTH_P{1'b1}};
                    ovf_d   = 1'b1;
                end else begin
                    total_d = acc_sum[WIDTH_P-1:0];
                    ovf_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: rtl/preco.sv
// Price calculator top: start/done handshake FSM around the shift-add datapath.
module preco
    import preco_pkg::*;
#(
    parameter int WIDTH_P = WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH_P-1:0] weight_kg,
    input  logic [WIDTH_P-1:0] price_per_kg,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [WIDTH_P-1:0] total_price
);

    state_e state_q, state_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   load;
    logic   step;
    logic   last;

    assign load = (state_q == IDLE) && start;
    assign step = (state_q == RUN);
    assign busy = busy_q;
    assign done = done_q;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    preco_shift_add #(.WIDTH_P(WIDTH_P)) u_dp (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .step         (step),
        .weight_kg    (weight_kg),
        .price_per_kg (price_per_kg),
        .last         (last),
        .total_price  (total_price),
        .overflow     (overflow)
    );

endmodule

// File: tb/tb_preco.sv
// Self-checking bench for preco: directed scenarios plus random operands
// against a plain-arithmetic saturating product model.
module tb_preco;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] weight_kg = '0;
    logic [15:0] price_per_kg = '0;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] total_price;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    preco dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .weight_kg    (weight_kg),
        .price_per_kg (price_per_kg),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .total_price  (total_price)
    );

    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] p, output logic o);
        longint prod;
        prod = longint'(a) * longint'(b);
        if (prod > 65535) begin
            p = 16'hFFFF;
            o = 1'b1;
        end else begin
            p = prod[15:0];
            o = 1'b0;
        end
    endfunction

    // Issues one request and waits (bounded) for done; no checking here.
    task automatic run_calc(input logic [15:0] a, input logic [15:0] b,
                            output int lat, output logic [15:0] p,
                            output logic o, output int busy_cnt);
        @(negedge clk);
        weight_kg = a;
        price_per_kg = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        p = total_price;
        o = overflow;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        weight_kg = 16'd123;
        price_per_kg = 16'd45;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, overflow, total_price} !== 19'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b total=%0d, want all 0",
                     busy, done, overflow, total_price);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [15:0] p;
        logic o;
        run_calc(16'd500, 16'd20, lat, p, o, bc);
        total++;
        if (lat !== 16) begin
            bad++;
            $display("FAIL basic_latency: got %0d, want 16", lat);
        end
        total++;
        if (bc !== 16) begin
            bad++;
            $display("FAIL basic_busy_cycles: got %0d, want 16", bc);
        end
        total++;
        if (p !== 16'd10000 || o !== 1'b0) begin
            bad++;
            $display("FAIL basic_result: got %0d ovf=%b, want 10000 ovf=0", p, o);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy_at_done: got %b, want 0", busy);
        end
        $display("basic 500x20 -> %0d ovf=%b lat=%0d", p, o, lat);
    endtask

    task automatic test_boundaries();
        logic [15:0] av [7] = '{16'd255, 16'd256, 16'd300, 16'd0, 16'd1234, 16'd1, 16'hFFFF};
        logic [15:0] bv [7] = '{16'd257, 16'd256, 16'd300, 16'd1234, 16'd0, 16'hFFFF, 16'hFFFF};
        int lat, bc;
        logic [15:0] p, ep;
        logic o, eo;
        for (int i = 0; i < 7; i++) begin
            run_calc(av[i], bv[i], lat, p, o, bc);
            model(av[i], bv[i], ep, eo);
            total++;
            if (p !== ep || o !== eo || lat !== 16) begin
                bad++;
                $display("FAIL boundary_%0dx%0d: got %0d ovf=%b lat=%0d, want %0d ovf=%b lat=16",
                         av[i], bv[i], p, o, lat, ep, eo);
            end
            $display("boundary %0dx%0d -> %0d ovf=%b lat=%0d", av[i], bv[i], p, o, lat);
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        int done_at = -1;
        logic [15:0] got = '0;
        @(negedge clk);
        weight_kg = 16'd500;
        price_per_kg = 16'd20;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin
                start = 1'b1;
                weight_kg = 16'd7;
                price_per_kg = 16'd7;
            end else begin
                start = 1'b0;
                weight_kg = 16'($urandom);
                price_per_kg = 16'($urandom);
            end
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                done_at = i;
                got = total_price;
            end
        end
        start = 1'b0;
        total++;
        if (dones !== 1 || done_at !== 16 || got !== 16'd10000) begin
            bad++;
            $display("FAIL ignore_start: got dones=%0d at=%0d val=%0d, want 1 at 16 val 10000",
                     dones, done_at, got);
        end
        $display("ignore_start dones=%0d at=%0d val=%0d", dones, done_at, got);
    endtask

    task automatic test_back_to_back();
        logic [15:0] av [3] = '{16'd12, 16'd300, 16'd99};
        logic [15:0] bv [3] = '{16'd34, 16'd300, 16'd101};
        int at [3] = '{-1, -1, -1};
        logic [15:0] got [3];
        int n = 0;
        logic [15:0] ep;
        logic eo;
        @(negedge clk);
        weight_kg = av[0];
        price_per_kg = bv[0];
        start = 1'b1;
        for (int e = 0; e <= 60 && n < 3; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                at[n] = e;
                got[n] = total_price;
                n++;
                if (n < 3) begin
                    weight_kg = av[n];
                    price_per_kg = bv[n];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            model(av[k], bv[k], ep, eo);
            total++;
            if (at[k] !== 16 + 17 * k || got[k] !== ep) begin
                bad++;
                $display("FAIL back_to_back_%0d: got edge=%0d val=%0d, want edge=%0d val=%0d",
                         k, at[k], got[k], 16 + 17 * k, ep);
            end
            $display("back_to_back %0d: edge=%0d val=%0d", k, at[k], got[k]);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_async_reset();
        int lat, bc;
        int dones = 0;
        logic [15:0] p;
        logic o;
        run_calc(16'd300, 16'd300, lat, p, o, bc);
        total++;
        if (p !== 16'hFFFF || o !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_sat: got %0d ovf=%b, want 65535 ovf=1", p, o);
        end
        @(negedge clk);
        weight_kg = 16'd500;
        price_per_kg = 16'd20;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, overflow, total_price} !== 19'd0) begin
            bad++;
            $display("FAIL async_reset: got busy=%b done=%b ovf=%b total=%0d, want all 0",
                     busy, done, overflow, total_price);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL no_done_after_abort: got %0d dones, want 0", dones);
        end
        run_calc(16'd3, 16'd4, lat, p, o, bc);
        total++;
        if (p !== 16'd12 || o !== 1'b0 || lat !== 16) begin
            bad++;
            $display("FAIL post_reset_3x4: got %0d ovf=%b lat=%0d, want 12 ovf=0 lat=16", p, o, lat);
        end
        $display("async_reset abort, then 3x4 -> %0d", p);
    endtask

    task automatic test_hold();
        int lat, bc;
        int errs = 0;
        logic [15:0] p;
        logic o;
        run_calc(16'd500, 16'd20, lat, p, o, bc);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start = 1'b0;
            weight_kg = 16'($urandom);
            price_per_kg = 16'($urandom);
            @(posedge clk);
            #1;
            total++;
            if (total_price !== 16'd10000 || overflow !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                errs++;
                if (errs < 4)
                    $display("FAIL hold_cycle_%0d: got %0d ovf=%b done=%b busy=%b, want 10000 0 0 0",
                             i, total_price, overflow, done, busy);
            end
        end
        $display("hold 50 idle cycles, value=%0d", total_price);
    endtask

    task automatic test_random();
        int lat, bc;
        logic [15:0] a, b, p, ep;
        logic o, eo;
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            b = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            run_calc(a, b, lat, p, o, bc);
            model(a, b, ep, eo);
            total++;
            if (p !== ep || o !== eo || lat !== 16) begin
                bad++;
                $display("FAIL random_%0dx%0d: got %0d ovf=%b lat=%0d, want %0d ovf=%b lat=16",
                         a, b, p, o, lat, ep, eo);
            end
            $display("random %0dx%0d -> %0d ovf=%b", a, b, p, o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
